// File: rtl/uart_arbiter.sv
// Two-requester byte arbiter feeding a UART write port: frame locking, round-robin
// between frames, ack timeout with sticky err. Optional macro: UART_ARB_INIT_DIV_EN.
module uart_arbiter #(
   parameter int DIV         = 39,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data_out,
   output logic       wb_we,
   output logic       wb_clk,
   output logic       wb_stb,
   input  logic       wb_ack,
   output logic       err
);

   typedef enum logic [1:0] {INIT, IDLE, STROBE, RELEASE} state_t;

`ifdef UART_ARB_INIT_DIV_EN
   localparam state_t     RST_STATE = INIT;
   localparam logic [7:0] DIV_BYTE  = DIV[7:0];
`else
   localparam state_t     RST_STATE = IDLE;
`endif
   localparam logic [7:0] TIMEOUT_CNT = ACK_TIMEOUT[7:0];

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt, cnt_inc;
   logic       locked, locked_nxt;
   logic       owner, owner_nxt;
   logic       prio, prio_nxt;
   logic       cur_req, cur_req_nxt;
   logic       cur_last, cur_last_nxt;
   logic       rdy0_nxt, rdy1_nxt;
   logic [1:0] addr_nxt;
   logic [7:0] data_nxt;
   logic       stb_nxt, wclk_nxt, err_nxt;
   logic       grant0, grant1;
   logic       timeout;
   logic       is_req_xfer;

`ifdef UART_ARB_INIT_DIV_EN
   logic init_wr, init_wr_nxt;
   assign is_req_xfer = !init_wr;
`else
   assign is_req_xfer = 1'b1;
`endif

   // The arbiter only ever writes to the UART.
   assign wb_we = 1'b0;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (locked) begin
         grant0 = req0_valid && !owner;
         grant1 = req1_valid && owner;
      end else if (req0_valid && req1_valid) begin
         grant0 = !prio;
         grant1 = prio;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      locked_nxt   = locked;
      owner_nxt    = owner;
      prio_nxt     = prio;
      cur_req_nxt  = cur_req;
      cur_last_nxt = cur_last;
      rdy0_nxt     = 1'b0;
      rdy1_nxt     = 1'b0;
      addr_nxt     = wb_addr;
      data_nxt     = wb_data_out;
      stb_nxt      = wb_stb;
      wclk_nxt     = wb_clk;
      err_nxt      = err;
      timeout      = 1'b0;
      cnt_inc      = cnt + 8'd1;
`ifdef UART_ARB_INIT_DIV_EN
      init_wr_nxt  = init_wr;
`endif
      case (state)
         INIT: begin
`ifdef UART_ARB_INIT_DIV_EN
            addr_nxt    = 2'd2;
            data_nxt    = DIV_BYTE;
            stb_nxt     = 1'b1;
            wclk_nxt    = 1'b1;
            cnt_nxt     = 8'd0;
            init_wr_nxt = 1'b1;
            state_nxt   = STROBE;
`else
            state_nxt   = IDLE;
`endif
         end
         IDLE: begin
            if (grant0 || grant1) begin
               addr_nxt     = 2'd0;
               data_nxt     = grant1 ? req1_data : req0_data;
               cur_last_nxt = grant1 ? req1_last : req0_last;
               cur_req_nxt  = grant1;
               rdy0_nxt     = grant0;
               rdy1_nxt     = grant1;
               stb_nxt      = 1'b1;
               wclk_nxt     = 1'b1;
               cnt_nxt      = 8'd0;
               state_nxt    = STROBE;
            end
         end
         STROBE: begin
            if (wb_ack) begin
               wclk_nxt  = 1'b0;
               cnt_nxt   = 8'd0;
               state_nxt = RELEASE;
            end else if (cnt_inc == TIMEOUT_CNT) begin
               timeout = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         RELEASE: begin
            if (!wb_ack) begin
               stb_nxt   = 1'b0;
               cnt_nxt   = 8'd0;
               state_nxt = IDLE;
               // Lock and priority move only when a requester byte fully completes.
               if (is_req_xfer) begin
                  if (cur_last) begin
                     locked_nxt = 1'b0;
                     prio_nxt   = !cur_req;
                  end else begin
                     locked_nxt = 1'b1;
                     owner_nxt  = cur_req;
                  end
               end
            end else if (cnt_inc == TIMEOUT_CNT) begin
               timeout = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Abandon the byte: no retry, frame lock dropped, priority untouched.
      if (timeout) begin
         err_nxt    = 1'b1;
         stb_nxt    = 1'b0;
         wclk_nxt   = 1'b0;
         locked_nxt = 1'b0;
         cnt_nxt    = 8'd0;
         state_nxt  = IDLE;
      end
`ifdef UART_ARB_INIT_DIV_EN
      if (state_nxt == IDLE) init_wr_nxt = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RST_STATE;
         cnt         <= 8'd0;
         locked      <= 1'b0;
         owner       <= 1'b0;
         prio        <= 1'b0;
         req0_ready  <= 1'b0;
         req1_ready  <= 1'b0;
         wb_addr     <= 2'd0;
         wb_data_out <= 8'd0;
         wb_stb      <= 1'b0;
         wb_clk      <= 1'b0;
         err         <= 1'b0;
`ifdef UART_ARB_INIT_DIV_EN
         init_wr     <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         locked      <= locked_nxt;
         owner       <= owner_nxt;
         prio        <= prio_nxt;
         req0_ready  <= rdy0_nxt;
         req1_ready  <= rdy1_nxt;
         wb_addr     <= addr_nxt;
         wb_data_out <= data_nxt;
         wb_stb      <= stb_nxt;
         wb_clk      <= wclk_nxt;
         err         <= err_nxt;
`ifdef UART_ARB_INIT_DIV_EN
         init_wr     <= init_wr_nxt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      cur_req  <= cur_req_nxt;
      cur_last <= cur_last_nxt;
   end

endmodule

// File: tb/tb_uart_arbiter.sv
// Bench for uart_arbiter: directed protocol steps plus randomized frames checked
// against a frame-level arbitration model.
module tb_uart_arbiter;
   localparam int DIV         = 6;
   localparam int ACK_TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = 8'd0, req1_data = 8'd0;
   logic       req0_last = 1'b0, req1_last = 1'b0;
   logic       req0_ready, req1_ready;
   logic [1:0] wb_addr;
   logic [7:0] wb_data_out;
   logic       wb_we, wb_clk, wb_stb, err;
   logic       wb_ack = 1'b0;

   always #5 clk = ~clk;

   uart_arbiter #(.DIV(DIV), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .wb_addr(wb_addr), .wb_data_out(wb_data_out), .wb_we(wb_we), .wb_clk(wb_clk),
      .wb_stb(wb_stb), .wb_ack(wb_ack), .err(err)
   );

   int checks = 0, errors = 0;
   logic [8:0] q0[$], q1[$];       // requester queues {last,data}
   logic [8:0] m0[$], m1[$];       // model copies
   logic [8:0] exp_q[$];           // expected accepted bytes {who,data}
   logic [8:0] rdy_log[$];         // observed accepted bytes {who,data}
   logic [9:0] bus_log[$];         // observed bus writes {addr,data}
   bit         m_prio = 1'b0;
   int         both_rdy = 0;
   bit         ack_auto = 1'b0;
   int         ack_cnt = 0, ack_dly = 0;
   logic       stb_q = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      req0_valid = (q0.size() != 0);
      {req0_last, req0_data} = req0_valid ? q0[0] : 9'd0;
      req1_valid = (q1.size() != 0);
      {req1_last, req1_data} = req1_valid ? q1[0] : 9'd0;
   endtask

   task automatic push_q(input bit who, input logic [7:0] d, input bit last);
      if (who) q1.push_back({last, d});
      else     q0.push_back({last, d});
   endtask

   task automatic push_m(input bit who, input logic [7:0] d, input bit last);
      if (who) m1.push_back({last, d});
      else     m0.push_back({last, d});
   endtask

   task automatic push_byte(input bit who, input logic [7:0] d, input bit last);
      push_q(who, d, last);
      push_m(who, d, last);
   endtask

   task automatic push_frame(input bit who, input int len);
      for (int i = 0; i < len; i++) push_byte(who, 8'($urandom), i == len - 1);
   endtask

   // Whole frames go out back to back; the requester that did not just finish wins ties.
   task automatic model_run();
      while (m0.size() != 0 || m1.size() != 0) begin
         bit pick;
         logic [8:0] b;
         pick = (m0.size() != 0 && m1.size() != 0) ? m_prio : (m0.size() == 0);
         do begin
            if (pick) begin b = m1[0]; m1.delete(0); end
            else      begin b = m0[0]; m0.delete(0); end
            exp_q.push_back({pick, b[7:0]});
         end while (!b[8]);
         m_prio = !pick;
      end
   endtask

   task automatic run_and_compare(input string tag, input int budget);
      int n;
      bit done;
      n = exp_q.size();
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         done = (rdy_log.size() >= n) && !wb_stb;
      end
      chk({tag, " done"}, done, 1);
      chk({tag, " count"}, rdy_log.size(), n);
      for (int i = 0; i < n && i < rdy_log.size(); i++)
         chk($sformatf("%s byte%0d", tag, i), rdy_log[i], exp_q[i]);
      chk({tag, " overlap"}, both_rdy, 0);
      exp_q.delete();
      rdy_log.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      ack_auto = 1'b0;
      wb_ack = 1'b0;
      q0.delete(); q1.delete(); m0.delete(); m1.delete(); exp_q.delete();
      refresh();
      repeat (2) @(negedge clk);
      bus_log.delete(); rdy_log.delete();
      both_rdy = 0; stb_q = 1'b0; m_prio = 1'b0; ack_cnt = 0; ack_dly = 0;
      reset = 1'b0;
      ack_auto = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   // Requester drivers, bus monitor and auto-acking UART, all just after each edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (req0_ready && req1_ready) both_rdy++;
         if (wb_stb && !stb_q) bus_log.push_back({wb_addr, wb_data_out});
         stb_q = wb_stb;
         if (req0_ready) begin
            rdy_log.push_back({1'b0, wb_data_out});
            if (q0.size() != 0) q0.delete(0);
         end
         if (req1_ready) begin
            rdy_log.push_back({1'b1, wb_data_out});
            if (q1.size() != 0) q1.delete(0);
         end
         refresh();
         if (ack_auto) begin
            if (!wb_ack && wb_stb && wb_clk) begin
               if (ack_cnt >= ack_dly) begin wb_ack = 1'b1; ack_cnt = 0; end
               else ack_cnt++;
            end else if (wb_ack && !wb_clk) begin
               if (ack_cnt >= ack_dly) begin
                  wb_ack = 1'b0; ack_cnt = 0; ack_dly = $urandom_range(0, 3);
               end else ack_cnt++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      // Outputs while reset is held
      repeat (3) @(negedge clk);
      chk("rst req0_ready", req0_ready, 0);
      chk("rst req1_ready", req1_ready, 0);
      chk("rst wb_stb", wb_stb, 0);
      chk("rst wb_clk", wb_clk, 0);
      chk("rst wb_we", wb_we, 0);
      chk("rst wb_addr", wb_addr, 0);
      chk("rst wb_data_out", wb_data_out, 0);
      chk("rst err", err, 0);

      // First bus write after reset
      do_reset();
      push_byte(0, 8'h33, 1'b1);
      model_run(); refresh();
      run_and_compare("first", 100);
`ifdef UART_ARB_INIT_DIV_EN
      chk("init writes", bus_log.size(), 2);
      chk("init div write", bus_log[0], {2'd2, 8'h06});
      chk("init then byte", bus_log[1], {2'd0, 8'h33});
`else
      chk("first writes", bus_log.size(), 1);
      chk("first write", bus_log[0], {2'd0, 8'h33});
`endif

      // Single write with a hand-driven ack two cycles after the strobe
      do_reset();
      ack_auto = 1'b0;
      push_byte(0, 8'h41, 1'b1);
      model_run(); refresh();
      @(negedge clk);
      chk("single ready0", req0_ready, 1);
      chk("single ready1", req1_ready, 0);
      chk("single stb", wb_stb, 1);
      chk("single wclk", wb_clk, 1);
      chk("single data", wb_data_out, 8'h41);
      chk("single addr", wb_addr, 0);
      chk("single we", wb_we, 0);
      @(negedge clk);
      chk("single ready pulse", req0_ready, 0);
      @(negedge clk);
      chk("single stb held", wb_stb, 1);
      chk("single wclk held", wb_clk, 1);
      wb_ack = 1'b1;
      @(negedge clk);
      chk("single wclk fall", wb_clk, 0);
      chk("single stb after ack", wb_stb, 1);
      wb_ack = 1'b0;
      @(negedge clk);
      chk("single stb fall", wb_stb, 0);
      run_and_compare("single", 10);

      // Contention: four single-byte frames each
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_frame(0, 1);
         push_frame(1, 1);
      end
      model_run(); refresh();
      run_and_compare("contend", 200);

      // Frame lock while req1 holds priority
      do_reset();
      push_byte(0, 8'h01, 1'b1);
      model_run(); refresh();
      run_and_compare("lock pre", 100);
      push_byte(0, 8'h10, 1'b0);
      push_byte(0, 8'h11, 1'b0);
      push_byte(0, 8'h12, 1'b1);
      model_run(); refresh();
      @(negedge clk);
      push_byte(1, 8'h20, 1'b1);
      model_run(); refresh();
      run_and_compare("lock", 200);

      // Locked owner goes quiet: the other requester must keep waiting
      push_m(0, 8'h30, 1'b0);
      push_m(0, 8'h31, 1'b1);
      model_run();
      push_m(1, 8'h40, 1'b1);
      model_run();
      push_q(0, 8'h30, 1'b0); refresh();
      repeat (2) @(negedge clk);
      push_q(1, 8'h40, 1'b1); refresh();
      repeat (20) @(negedge clk);
      chk("stall accepted", rdy_log.size(), 1);
      chk("stall bus idle", wb_stb, 0);
      push_q(0, 8'h31, 1'b1); refresh();
      run_and_compare("stall", 100);

      // Ack never arrives
      do_reset();
      ack_auto = 1'b0;
      push_byte(0, 8'h55, 1'b1);
      model_run(); refresh();
      @(negedge clk);
      chk("to grant stb", wb_stb, 1);
      chk("to grant ready", req0_ready, 1);
      repeat (7) @(negedge clk);
      chk("to err early", err, 0);
      chk("to stb early", wb_stb, 1);
      @(negedge clk);
      chk("to err", err, 1);
      chk("to stb", wb_stb, 0);
      chk("to wclk", wb_clk, 0);
      ack_auto = 1'b1;
      push_byte(1, 8'h66, 1'b1);
      model_run(); refresh();
      run_and_compare("timeout", 100);
      chk("to err sticky", err, 1);

      // Reset in the middle of a strobe, with req1 holding priority and err set
      push_byte(0, 8'h70, 1'b1);
      model_run(); refresh();
      run_and_compare("rst pre", 100);
      ack_auto = 1'b0;
      push_q(1, 8'h71, 1'b1); refresh();
      @(negedge clk);
      chk("rst mid stb", wb_stb, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst mid stb low", wb_stb, 0);
      chk("rst mid wclk low", wb_clk, 0);
      chk("rst mid err", err, 0);
      chk("rst mid ready1", req1_ready, 0);
      do_reset();
      push_byte(1, 8'h81, 1'b1);
      push_byte(0, 8'h80, 1'b1);
      model_run(); refresh();
      run_and_compare("post reset", 100);

      // Randomized frames and ack delays
      for (int r = 0; r < 6; r++) begin
         int nf0, nf1;
         nf0 = $urandom_range(0, 3);
         nf1 = $urandom_range(0, 3);
         for (int f = 0; f < nf0; f++) push_frame(0, $urandom_range(1, 3));
         for (int f = 0; f < nf1; f++) push_frame(1, $urandom_range(1, 3));
         model_run(); refresh();
         run_and_compare($sformatf("rand%0d", r), 500);
      end
      chk("rand err clear", err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter DIV, default 39: frequency divider value written at init.
REQ-002 Parameter ACK_TIMEOUT, default 255: maximum cycles to wait for each ack edge; 8-bit count.
REQ-003 Port clk, input, 1: sole clock; all logic on posedge clk.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Ports req0_valid / req1_valid, input, 1: requester has a byte.
REQ-006 Ports req0_data / req1_data, input, 8: byte to transmit; held stable while valid and not ready.
REQ-007 Ports req0_last / req1_last, input, 1: byte ends the requester's frame.
REQ-008 Ports req0_ready / req1_ready, output, 1: one-cycle pulse; byte accepted.
REQ-009 Port wb_addr, output, 2: UART register address.
REQ-010 Port wb_data_out, output, 8: data to UART wb_data_in.
REQ-011 Ports wb_we, wb_clk, wb_stb, output, 1 each: UART bus controls; wb_we LOW = write.
REQ-012 Port wb_ack, input, 1: UART acknowledge.
REQ-013 Port err, output, 1: sticky ack-timeout flag.

Function
REQ-014 States: INIT, IDLE, STROBE, RELEASE. All outputs are registered.
REQ-015 IDLE: if exactly one valid, or if the frame owner is valid, grant it; else, if both are valid, grant the round-robin winner.
REQ-016 Grant cycle: latch data into wb_data_out; set wb_addr=0, wb_we=0, wb_stb=1, wb_clk=1; pulse the granted reqN_ready; go to STROBE.
REQ-017 STROBE: on wb_ack=1, drive wb_clk=0 and go to RELEASE; wb_stb stays 1.
REQ-018 RELEASE: on wb_ack=0, drive wb_stb=0 and go to IDLE; minimum of 3 cycles from grant to the next grant.
REQ-019 Frame lock: after a byte with last=0, that requester owns the bus; the other is not granted until the owner's byte with last=1 completes RELEASE.
REQ-020 While locked, IDLE waits for the owner's valid indefinitely; the other requester's ready stays 0.
REQ-021 Round-robin: after a frame ends (last=1), priority goes to the other requester.
REQ-022 Priority after reset is req0.
REQ-023 Only one reqN_ready is asserted in any cycle.
REQ-024 Timeout counter clears on entry to STROBE and to RELEASE, and increments each cycle in those states.
REQ-025 When the counter reaches ACK_TIMEOUT: set err=1, drive wb_stb=0 and wb_clk=0, clear the frame lock, go to IDLE; the byte is lost, with no retry.
REQ-026 err clears only on reset.
REQ-027 Requester valid deasserted mid-frame: the lock persists (REQ-020).
REQ-028 Arbiter never issues reads; wb_we is constant 0.

Reset
REQ-029 On reset: wb_stb=0, wb_clk=0, wb_we=0, wb_addr=0, wb_data_out=0, req0_ready=0, req1_ready=0, err=0.
REQ-030 On reset: lock cleared, priority=req0, counter=0.
REQ-031 On reset: state=INIT if UART_ARB_INIT_DIV_EN is defined, else IDLE.
REQ-032 Reset asserted mid-transfer aborts at the next edge; the byte is lost with no ready re-pulse.

Configuration
REQ-033 Macro UART_ARB_INIT_DIV_EN.
REQ-034 Defined: INIT performs one write of DIV[7:0] to wb_addr=2, using the STROBE/RELEASE handshake and timeout rules, then enters IDLE; no ready pulses occur during INIT.
REQ-035 Undefined: INIT logic is absent; reset goes directly to IDLE; the UART keeps its own default divider.

Verification
REQ-036 Single write: req0 sends 0x41 last=1, UART acks after 2 cycles → one req0_ready pulse; wb_data_out=0x41, wb_addr=0, wb_we=0; wb_clk falls after ack; wb_stb falls after ack drops.
REQ-037 Contention: both valid continuously, all last=1, 4 bytes each → grants alternate 0,1,0,1,...; 8 ready pulses total; never simultaneous.
REQ-038 Frame lock: req0 sends 0x10,0x11,0x12 (last on 0x12) while req1 is valid → bytes 0x10-0x12 are contiguous on the bus, then req1's byte follows.
REQ-039 Timeout: wb_ack held 0, ACK_TIMEOUT=8 → err=1 eight cycles after grant; wb_stb=0; the next request is still served.
REQ-040 Init (macro defined, DIV=6) → first bus write is addr=2, data=0x06, before any requester byte; with the macro undefined, the first write is a requester byte.
REQ-041 Reset during STROBE → next cycle wb_stb=0, wb_clk=0, err=0; then arbitration resumes with req0 priority.
